// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 1..NB_DATA data bits, none/even/odd parity, 1 or 2 stop bits.
// A one-deep holding register with a valid/ready handshake lets frames run back to back.
module uart_tx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                           clk,
  input  logic                           i_rst_n,
  input  logic                           i_tick,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [NB_DATA-1:0]             i_data,
  input  logic [$clog2(NB_DATA+1)-1:0]   i_nbits,
  input  logic [1:0]                     i_parity,
  input  logic                           i_stop2,
  output logic                           o_data,
  output logic                           o_busy,
  output logic                           o_txdone
);

  localparam int NW = $clog2(NB_DATA + 1);
  localparam int CW = $clog2(2 * OVERSAMPLE);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [CW-1:0] OS_LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] STOP2_LAST = CW'(2 * OVERSAMPLE - 1);
  localparam logic [NW-1:0] NB_MAX     = NW'(NB_DATA);

  function automatic logic parity_xor(input logic [NB_DATA-1:0] d, input logic [NW-1:0] n);
    logic x;
    x = 1'b0;
    for (int unsigned i = 0; i < NB_DATA; i++) begin
      if (NW'(i) < n) x = x ^ d[i];
    end
    return x;
  endfunction

  logic [2:0]         state;
  logic [CW-1:0]      tick_cnt;
  logic [NW-1:0]      bit_cnt;
  logic [NB_DATA-1:0] shift;
  logic [NB_DATA-1:0] shift_nx;
  logic [NW-1:0]      f_nbits;
  logic               f_par_en;
  logic               f_par_bit;
  logic               f_stop2;

  logic [NB_DATA-1:0] hold_data;
  logic [NW-1:0]      hold_nbits;
  logic [1:0]         hold_parity;
  logic               hold_stop2;
  logic               hold_valid;

  logic               xfer;
  logic               bypass;
  logic               bit_end;
  logic               stop_done;
  logic               load_now;
  logic [NB_DATA-1:0] ld_data;
  logic [NW-1:0]      ld_nbits;
  logic [1:0]         ld_parity;
  logic               ld_stop2;
  logic [NW-1:0]      ld_nb_eff;
  logic               ld_par_en;
  logic               ld_par_bit;

  assign o_ready  = !hold_valid;
  assign o_busy   = (state != IDLE) || hold_valid;
  assign xfer     = i_valid && o_ready;
  assign shift_nx = shift >> 1;

  // A word offered while idle goes straight to the shifter and never occupies hold.
  assign bypass    = (state == IDLE) && !hold_valid && xfer;
  assign bit_end   = (tick_cnt == (((state == STOP) && f_stop2) ? STOP2_LAST : OS_LAST));
  assign stop_done = (state == STOP) && i_tick && bit_end;
  assign load_now  = ((state == IDLE) && (xfer || hold_valid)) || (stop_done && hold_valid);

  always_comb begin
    ld_data   = hold_valid ? hold_data   : i_data;
    ld_nbits  = hold_valid ? hold_nbits  : i_nbits;
    ld_parity = hold_valid ? hold_parity : i_parity;
    ld_stop2  = hold_valid ? hold_stop2  : i_stop2;
    ld_nb_eff = ((ld_nbits == '0) || (ld_nbits > NB_MAX)) ? NB_MAX : ld_nbits;
    ld_par_en = (ld_parity == 2'b01) || (ld_parity == 2'b10);
    ld_par_bit = parity_xor(ld_data, ld_nb_eff) ^ (ld_parity == 2'b10);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      hold_nbits  <= '0;
      hold_parity <= '0;
      hold_stop2  <= 1'b0;
    end else if (xfer && !bypass) begin
      hold_valid  <= 1'b1;
      hold_data   <= i_data;
      hold_nbits  <= i_nbits;
      hold_parity <= i_parity;
      hold_stop2  <= i_stop2;
    end else if (load_now && hold_valid) begin
      hold_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      f_nbits   <= '0;
      f_par_en  <= 1'b0;
      f_par_bit <= 1'b0;
      f_stop2   <= 1'b0;
      o_data    <= 1'b1;
      o_txdone  <= 1'b0;
    end else begin
      o_txdone <= 1'b0;
      if ((state != IDLE) && i_tick) begin
        if (!bit_end) begin
          tick_cnt <= tick_cnt + 1'b1;
        end else begin
          tick_cnt <= '0;
          case (state)
            START: begin
              state  <= DATA;
              o_data <= shift[0];
            end
            DATA: begin
              if (bit_cnt == f_nbits - NW'(1)) begin
                bit_cnt <= '0;
                state   <= f_par_en ? PARITY : STOP;
                o_data  <= f_par_en ? f_par_bit : 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shift   <= shift_nx;
                o_data  <= shift_nx[0];
              end
            end
            PARITY: begin
              state  <= STOP;
              o_data <= 1'b1;
            end
            STOP: begin
              o_txdone <= 1'b1;
              state    <= IDLE;
              o_data   <= 1'b1;
            end
            default: begin
              state  <= IDLE;
              o_data <= 1'b1;
            end
          endcase
        end
      end
      // Loading a frame overrides the stop-to-idle move above, giving a gapless restart.
      if (load_now) begin
        state     <= START;
        o_data    <= 1'b0;
        tick_cnt  <= '0;
        bit_cnt   <= '0;
        shift     <= ld_data;
        f_nbits   <= ld_nb_eff;
        f_par_en  <= ld_par_en;
        f_par_bit <= ld_par_bit;
        f_stop2   <= ld_stop2;
      end
    end
  end

endmodule
